addsub_rr_arbiter: RTL and testbench

- Shares one `add_sub_8bit` datapath between two requesters.
- Round-robin arbitration, valid/ready request and response handshakes.
- Registers the operands, result and signed overflow flag.
- Sits between the two client blocks and the single add/sub unit. Exactly one operation is in flight at a time.

---
 rtl/addsub_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_addsub_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_arbiter.sv
// Round-robin front end sharing one 8-bit add/sub datapath between two clients.
// One operation in flight: accept, calculate, then hold the response until taken.

module add_sub_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] sum
);

    // Subtraction as a + ~b + 1
    assign sum = a + (b ^ {8{sub}}) + {7'd0, sub};

endmodule

module addsub_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovfl
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic             op_mode;
    logic             op_id;
    logic             last_grant;

    logic             gnt0, gnt1;
    logic [WIDTH-1:0] sum;
    logic             ovfl;
    logic             sa, sb, ss;

    // On contention the requester that did not win last time goes next
    assign gnt0 = req0_valid && (!req1_valid || last_grant);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = (state_q == IDLE) && gnt0;
    assign req1_ready = (state_q == IDLE) && gnt1;

    add_sub_8bit u_addsub (
        .a   (op_a),
        .b   (op_b),
        .sub (op_mode),
        .sum (sum)
    );

    assign sa = op_a[WIDTH-1];
    assign sb = op_b[WIDTH-1];
    assign ss = sum[WIDTH-1];

    always_comb begin
        ovfl = 1'b0;
        if (op_mode) begin
            ovfl = (sa != sb) && (ss != sa);
        end else begin
            ovfl = (sa == sb) && (ss != sa);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_mode    <= 1'b0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_ovfl   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt0) begin
                        op_a    <= req0_a;
                        op_b    <= req0_b;
                        op_mode <= req0_mode;
                        op_id   <= 1'b0;
                    end else if (gnt1) begin
                        op_a    <= req1_a;
                        op_b    <= req1_b;
                        op_mode <= req1_mode;
                        op_id   <= 1'b1;
                    end
                end
                CALC: begin
                    rsp_result <= sum;
                    rsp_ovfl   <= ovfl;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Bench for addsub_rr_arbiter: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.

module tb_addsub_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_mode;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_mode;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_ovfl;
    logic [7:0] rsp_result;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    addsub_rr_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ovfl   (rsp_ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = waiting for a request, 1 = operation taken, 2 = answer offered
    int         m_phase;
    bit         m_last;
    bit         m_pid;
    bit [7:0]   m_pres;
    bit         m_povf;
    bit         m_valid, m_id, m_ovfl;
    bit [7:0]   m_result;

    function automatic void golden(input bit [7:0] a, input bit [7:0] b, input bit sub,
                                   output bit [7:0] r, output bit o);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s = sub ? sa - sb : sa + sb;
        r = s[7:0];
        o = (s > 127) || (s < -128);
    endfunction

    function automatic bit exp_rdy0();
        return (m_phase == 0) && req0_valid && (!req1_valid || m_last);
    endfunction

    function automatic bit exp_rdy1();
        return (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_last = 1; m_pid = 0; m_pres = 0; m_povf = 0;
            m_valid = 0; m_id = 0; m_result = 0; m_ovfl = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (exp_rdy0()) begin
                        golden(req0_a, req0_b, req0_mode, m_pres, m_povf);
                        m_pid = 0; m_phase = 1;
                    end else if (exp_rdy1()) begin
                        golden(req1_a, req1_b, req1_mode, m_pres, m_povf);
                        m_pid = 1; m_phase = 1;
                    end
                end
                1: begin
                    m_valid = 1; m_id = m_pid; m_result = m_pres; m_ovfl = m_povf;
                    m_phase = 2;
                end
                default: begin
                    if (rsp_ready) begin
                        m_valid = 0; m_last = m_id; m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rsp_valid", rsp_valid, m_valid);
            check("m_rsp_id", rsp_id, m_id);
            check("m_rsp_result", rsp_result, m_result);
            check("m_rsp_ovfl", rsp_ovfl, m_ovfl);
            check("m_req0_ready", req0_ready, exp_rdy0());
            check("m_req1_ready", req1_ready, exp_rdy1());
        end
    end

    task automatic idle_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_mode = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_mode = 0;
        rsp_ready = 1;
    endtask

    task automatic drive(input bit id, input bit [7:0] a, input bit [7:0] b, input bit m);
        if (id) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_mode = m;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_mode = m;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        idle_inputs();
        @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    // Wait for rsp_valid at a negedge; returns cycles waited
    task automatic wait_rsp(input string nm, output int n);
        bit got;
        got = 0; n = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; n = i; end
        end
        if (!got) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string nm, input bit id, input bit [7:0] a, input bit [7:0] b,
                          input bit m, input bit [7:0] er, input bit eo);
        bit got;
        int n;
        rsp_ready = 1;
        drive(id, a, b, m);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) got = 1;
        end
        check({nm, "_accept"}, got, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
        @(negedge clk);
        check({nm, "_ready_pulse"}, id ? req1_ready : req0_ready, 0);
        wait_rsp(nm, n);
        check({nm, "_latency"}, n, 1);
        check({nm, "_id"}, rsp_id, id);
        check({nm, "_result"}, rsp_result, er);
        check({nm, "_ovfl"}, rsp_ovfl, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit [7:0] held;
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", rsp_valid, 0);
        check("reset_result", rsp_result, 0);
        check("reset_id", rsp_id, 0);
        check("reset_ovfl", rsp_ovfl, 0);
        @(posedge clk); #3;
        rst_n = 1;
        chk_en = 1;
        @(posedge clk); #1;

        // Contention straight after reset: strict alternation starting with 0
        drive(0, 8'h06, 8'h01, 0);
        drive(1, 8'h06, 8'h01, 1);
        for (int k = 0; k < 4; k++) begin
            wait_rsp("contend", n);
            check("contend_id", rsp_id, k[0]);
            check("contend_result", rsp_result, k[0] ? 32'h05 : 32'h07);
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;

        run_op("add_a", 0, 8'h01, 8'hF9, 0, 8'hFA, 0);
        run_op("add_b", 1, 8'h6D, 8'h45, 0, 8'hB2, 1);
        run_op("sub_a", 0, 8'h80, 8'h01, 1, 8'h7F, 1);
        run_op("sub_b", 1, 8'h85, 8'h21, 1, 8'h64, 1);
        run_op("sub_c", 0, 8'h80, 8'h9C, 1, 8'hE4, 0);

        // Backpressure with a competing request pending
        rsp_ready = 0;
        drive(0, 8'h15, 8'h31, 0);
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0;
        drive(1, 8'h22, 8'h11, 1);
        wait_rsp("bp", n);
        held = rsp_result;
        check("bp_result", held, 8'h46);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_id", rsp_id, 0);
            check("bp_hold_result", rsp_result, 8'h46);
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        check("bp_released_valid", rsp_valid, 1);
        @(negedge clk);
        check("bp_done_valid", rsp_valid, 0);
        check("bp_idle_grant", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 0;
        wait_rsp("bp_next", n);
        check("bp_next_result", rsp_result, 8'h11);
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset while the operation is in its calculate cycle
        drive(1, 8'h10, 8'h20, 0);
        @(negedge clk);
        @(posedge clk); #2;
        req1_valid = 0;
        rst_n = 0;
        #1;
        check("rst_calc_valid", rsp_valid, 0);
        check("rst_calc_result", rsp_result, 0);
        check("rst_calc_id", rsp_id, 0);
        drive(0, 8'h01, 8'h02, 0);
        drive(1, 8'h03, 8'h04, 0);
        @(posedge clk); #3;
        rst_n = 1;
        @(negedge clk);
        check("rst_first_grant0", req0_ready, 1);
        check("rst_first_grant1", req1_ready, 0);
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic, model comparison runs every cycle
        for (int c = 0; c < 3000; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_mode = 1'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_mode = 1'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #2 rst_n = 0;
                #2 rst_n = 1;
            end
            @(posedge clk); #1;
        end

        idle_inputs();
        repeat (5) @(posedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
